// File: rtl/dac_writer.sv
// dac_writer: serial transmitter for a 16-bit SPI-style DAC frame
// ({2'b00, pd, din}, MSB first). A word is taken through a valid/ready handshake,
// shifted out on cs_n/s_data, then the block holds cs_n high for a guard gap
// before it accepts the next word. All outputs are registered on rising sclk.
module dac_writer #(
  parameter int unsigned GAP_CYCLES = 2  // legal range 1..15
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [11:0] din,
  input  logic [1:0]  pd,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        cs_n,
  output logic        s_data,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  localparam logic [3:0] GapLoad = 4'(GAP_CYCLES);

  state_e      state;
  logic [15:0] shreg;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;

  // Frame sequencer: handshake, bit shifting and inter-frame gap, with every
  // output updated in the same registered process so nothing is combinational.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= StIdle;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      din_ready <= 1'b1;
      cs_n      <= 1'b1;
      s_data    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (din_valid && din_ready) begin
            // Bit 15 of the frame (always 0) goes out now; the register keeps
            // the remaining 15 bits left-aligned so its MSB is the next bit.
            shreg     <= {1'b0, pd, din, 1'b0};
            s_data    <= 1'b0;
            cs_n      <= 1'b0;
            din_ready <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= 4'd15;
            state     <= StShift;
          end
        end
        StShift: begin
          if (bit_cnt == 4'd0) begin
            // Bit 0 has been presented for a full cycle: close the frame.
            cs_n    <= 1'b1;
            s_data  <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= GapLoad;
            state   <= StGap;
          end else begin
            s_data  <= shreg[15];
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        StGap: begin
          if (gap_cnt <= 4'd1) begin
            gap_cnt   <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_writer.sv
// tb_dac_writer: drives three dac_writer instances (gap 2, 1, 15) with shared
// stimulus and compares every output each cycle against a per-instance
// frame-timing model expressed as offsets from the acceptance edge.
module tb_dac_writer;

  localparam int NI = 3;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] din = '0;
  logic [1:0]  pd = '0;
  logic        din_valid = 1'b0;

  logic [NI-1:0] ready, cs_n, s_data, done, busy;

  dac_writer #(.GAP_CYCLES(2)) u_g2 (
    .sclk(sclk), .rst(rst), .din(din), .pd(pd), .din_valid(din_valid),
    .din_ready(ready[0]), .cs_n(cs_n[0]), .s_data(s_data[0]), .done(done[0]),
    .busy(busy[0])
  );

  dac_writer #(.GAP_CYCLES(1)) u_g1 (
    .sclk(sclk), .rst(rst), .din(din), .pd(pd), .din_valid(din_valid),
    .din_ready(ready[1]), .cs_n(cs_n[1]), .s_data(s_data[1]), .done(done[1]),
    .busy(busy[1])
  );

  dac_writer #(.GAP_CYCLES(15)) u_g15 (
    .sclk(sclk), .rst(rst), .din(din), .pd(pd), .din_valid(din_valid),
    .din_ready(ready[2]), .cs_n(cs_n[2]), .s_data(s_data[2]), .done(done[2]),
    .busy(busy[2])
  );

  always #5 sclk = ~sclk;

  // Model state: latest frame per instance, located by its acceptance edge.
  int          edge_cnt = 0;
  bit          act  [NI];
  int          n0   [NI];
  logic [15:0] word [NI];
  bit          acc  [NI];

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] cap = '0;
  int          n_done = 0;

  function automatic int gap_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Ready as seen after edge e: no frame, or frame plus gap fully elapsed.
  function automatic bit m_ready(input int i, input int e);
    return !act[i] || ((e - n0[i]) >= 16 + gap_of(i));
  endfunction

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[gap=%0d] edge %0d: observed %b expected %b",
             tag, gap_of(i), edge_cnt, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %0h expected %0h", tag, edge_cnt, obs, exp);
    end
  endtask

  // One clock: update the model at the rising edge, check outputs at the falling edge.
  task automatic tick();
    int   d;
    logic e_cs, e_sd, e_done, e_busy, e_rdy;
    @(posedge sclk);
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        act[i] = 1'b0;
      end else if (m_ready(i, edge_cnt) && din_valid) begin
        act[i]  = 1'b1;
        n0[i]   = edge_cnt + 1;
        word[i] = {2'b00, pd, din};
        acc[i]  = 1'b1;
      end
    end
    edge_cnt++;
    @(negedge sclk);
    for (int i = 0; i < NI; i++) begin
      if (!act[i]) begin
        e_cs = 1'b1; e_sd = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
      end else begin
        d      = edge_cnt - n0[i];
        e_cs   = !(d <= 15);
        e_sd   = (d <= 15) ? word[i][15 - d] : 1'b0;
        e_done = (d == 16);
        e_busy = (d <= 15 + gap_of(i));
        e_rdy  = (d >= 16 + gap_of(i));
      end
      chk("cs_n", i, cs_n[i], e_cs);
      chk("s_data", i, s_data[i], e_sd);
      chk("done", i, done[i], e_done);
      chk("busy", i, busy[i], e_busy);
      chk("din_ready", i, ready[i], e_rdy);
    end
    if (cs_n[0] === 1'b0) cap = {cap[14:0], s_data[0]};
    if (done[0] === 1'b1) n_done++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [11:0] b2b [3];
  int          guard;

  initial begin
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0; n0[i] = 0; word[i] = '0; acc[i] = 1'b0;
    end
    b2b[0] = 12'h001; b2b[1] = 12'h800; b2b[2] = 12'h7FF;

    // Reset
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    // Single frame
    cap = '0;
    din = 12'hA5C; pd = 2'b00; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    run(35);
    chkv("stream_a5c", {16'h0, cap}, 32'h0000_0A5C);

    // Power-down code; din changed right after acceptance
    cap = '0;
    din = 12'hFFF; pd = 2'b11; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 12'h000; pd = 2'b00;
    run(35);
    chkv("stream_pd", {16'h0, cap}, 32'h0000_3FFF);

    // Back-to-back with valid held high
    n_done = 0;
    din_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      din = b2b[w];
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!acc[0] && guard < 40);
      chkv("b2b_accept", {31'h0, acc[0]}, 32'h1);
    end
    din_valid = 1'b0;
    run(40);
    chkv("b2b_done_count", n_done, 3);
    chkv("b2b_last_stream", {16'h0, cap}, 32'h0000_07FF);

    // Valid while busy with a different word
    cap = '0;
    din = 12'h456; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    run(5);
    din = 12'h789; din_valid = 1'b1;
    run(30);
    din_valid = 1'b0;
    run(40);
    chkv("busy_valid_stream", {16'h0, cap}, 32'h0000_0789);

    // Reset after 7 bits, then a clean frame
    din = 12'hFFF; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    run(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cap = '0;
    din = 12'h123; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    run(35);
    chkv("post_reset_stream", {16'h0, cap}, 32'h0000_0123);

    // Randomised traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      din       = 12'($urandom);
      pd        = 2'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    din_valid = 1'b0;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
